// File: rtl/tt_um_hoene_pwm_scheduler.sv
// Colour-update scheduler feeding the LED PWM duty registers: immediate, fade, hold or blank.
// Optional fade engine enabled by defining TT_HOENE_PWM_FADE_EN.
//
// state | meaning
// IDLE  | outputs stable, waiting for an accepted frame
// LOAD  | copy registered target to outputs, then back to IDLE
// FADE  | step outputs toward target once per tick until equal
module tt_um_hoene_pwm_scheduler #(
    parameter int WIDTH    = 10,
    parameter int TICK_DIV = 256,
    parameter int STEP     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      in_word,
    input  logic             in_set,
    input  logic             in_error,
    input  logic             in_sync,
    output logic [WIDTH-1:0] out_red,
    output logic [WIDTH-1:0] out_green,
    output logic [WIDTH-1:0] out_blue,
    output logic             busy,
    output logic             update
);

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $fatal(1, "TICK_DIV must be at least 2");
    end
    if (STEP < 1) begin : g_bad_step
        $fatal(1, "STEP must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FADE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] red_q, green_q, blue_q;
    logic [WIDTH-1:0] red_d, green_d, blue_d;
    logic [WIDTH-1:0] tgt_r_q, tgt_g_q, tgt_b_q;
    logic [WIDTH-1:0] tgt_r_d, tgt_g_d, tgt_b_d;
    logic [WIDTH-1:0] frm_r, frm_g, frm_b;
    logic [1:0]       mode;
    logic             accept;
    logic             new_frame;
    logic             fade_mode;
    logic             busy_q, update_q;

    assign mode      = in_word[31:30];
    assign accept    = in_set & ~in_error & in_sync;
    // Hold frames are accepted but must not disturb anything, including a running fade.
    assign new_frame = accept && (mode != 2'b10);
    assign frm_r     = (mode == 2'b11) ? '0 : WIDTH'(in_word[29:20]);
    assign frm_g     = (mode == 2'b11) ? '0 : WIDTH'(in_word[19:10]);
    assign frm_b     = (mode == 2'b11) ? '0 : WIDTH'(in_word[9:0]);

`ifdef TT_HOENE_PWM_FADE_EN
    localparam int               CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [WIDTH:0]   STEP_W   = (WIDTH + 1)'(STEP);

    logic [CNT_W-1:0] cnt_q;
    logic             tick;
    logic [WIDTH-1:0] st_r, st_g, st_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

    // Difference taken one bit wider so the direction and magnitude never wrap.
    function automatic logic [WIDTH-1:0] step_ch(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] tgt);
        logic [WIDTH:0] diff;
        logic [WIDTH:0] mag;
        diff = {1'b0, tgt} - {1'b0, cur};
        mag  = diff[WIDTH] ? (-diff) : diff;
        if (mag <= STEP_W) begin
            step_ch = tgt;
        end else if (diff[WIDTH]) begin
            step_ch = cur - WIDTH'(STEP);
        end else begin
            step_ch = cur + WIDTH'(STEP);
        end
    endfunction

    assign st_r      = step_ch(red_q, tgt_r_q);
    assign st_g      = step_ch(green_q, tgt_g_q);
    assign st_b      = step_ch(blue_q, tgt_b_q);
    assign fade_mode = (mode == 2'b01);
`else
    assign fade_mode = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        tgt_r_d = tgt_r_q;
        tgt_g_d = tgt_g_q;
        tgt_b_d = tgt_b_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;

        case (state_q)
            LOAD: begin
                red_d   = tgt_r_q;
                green_d = tgt_g_q;
                blue_d  = tgt_b_q;
                state_d = IDLE;
            end
`ifdef TT_HOENE_PWM_FADE_EN
            FADE: begin
                if (!in_sync) begin
                    state_d = IDLE;
                end else if (!new_frame) begin
                    if (tick) begin
                        red_d   = st_r;
                        green_d = st_g;
                        blue_d  = st_b;
                    end
                    if (red_d == tgt_r_q && green_d == tgt_g_q && blue_d == tgt_b_q) begin
                        state_d = IDLE;
                    end
                end
            end
`endif
            default: begin
            end
        endcase

        if (new_frame) begin
            tgt_r_d = frm_r;
            tgt_g_d = frm_g;
            tgt_b_d = frm_b;
            state_d = fade_mode ? FADE : LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tgt_r_q  <= '0;
            tgt_g_q  <= '0;
            tgt_b_q  <= '0;
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
            busy_q   <= 1'b0;
            update_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_r_q  <= tgt_r_d;
            tgt_g_q  <= tgt_g_d;
            tgt_b_q  <= tgt_b_d;
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
            busy_q   <= (state_d != IDLE);
            update_q <= (red_d != red_q) || (green_d != green_q) || (blue_d != blue_q);
        end
    end

    assign out_red   = red_q;
    assign out_green = green_q;
    assign out_blue  = blue_q;
    assign busy      = busy_q;
    assign update    = update_q;

endmodule

// File: tb/tb_tt_um_hoene_pwm_scheduler.sv
// Scoreboard bench for tt_um_hoene_pwm_scheduler; fade cases run when TT_HOENE_PWM_FADE_EN is defined.
module tb_tt_um_hoene_pwm_scheduler;
    localparam int WIDTH    = 10;
    localparam int TICK_DIV = 8;
    localparam int STEP     = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      in_word;
    logic             in_set, in_error, in_sync;
    logic [WIDTH-1:0] out_red, out_green, out_blue;
    logic             busy, update;

    int checks   = 0;
    int fails    = 0;
    int n_popped = 0;
    logic [29:0] sb[$];

    tt_um_hoene_pwm_scheduler #(.WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_set(in_set),
        .in_error(in_error), .in_sync(in_sync), .out_red(out_red),
        .out_green(out_green), .out_blue(out_blue), .busy(busy), .update(update)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [29:0] rgb(input int r, input int g, input int b);
        return {10'(r), 10'(g), 10'(b)};
    endfunction

    // Monitor: every update pulse must match the next queued colour triple.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && update === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_update: got %0h expected no update",
                         {out_red, out_green, out_blue});
            end else begin
                chk("sb_colour", {2'b00, out_red, out_green, out_blue}, {2'b00, sb.pop_front()});
                n_popped++;
            end
        end
    end

    task automatic send(input logic [1:0] mode, input int r, input int g, input int b,
                        input logic err, input logic sync);
        in_word  = {mode, rgb(r, g, b)};
        in_set   = 1'b1;
        in_error = err;
        in_sync  = sync;
        @(posedge clk);
        #1;
        in_set   = 1'b0;
        in_error = 1'b0;
        in_sync  = 1'b1;
        in_word  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_imm(input string name, input logic [1:0] mode,
                              input int r, input int g, input int b,
                              input int er, input int eg, input int eb);
        sb.push_back(rgb(er, eg, eb));
        send(mode, r, g, b, 1'b0, 1'b1);
        chk({name, "_busy_e"}, {31'd0, busy}, 32'd1);
        chk({name, "_upd_e"}, {31'd0, update}, 32'd0);
        @(posedge clk);
        #1;
        chk({name, "_out"}, {2'b00, out_red, out_green, out_blue}, {2'b00, rgb(er, eg, eb)});
        chk({name, "_upd_e1"}, {31'd0, update}, 32'd1);
        chk({name, "_busy_e1"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk({name, "_upd_once"}, {31'd0, update}, 32'd0);
    endtask

    task automatic wait_pops(input string name, input int target, input int budget);
        int k = 0;
        while (n_popped < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk({name, "_pops"}, n_popped, target);
    endtask

    task automatic expect_drop(input string name, input logic [1:0] mode,
                               input logic err, input logic sync);
        send(mode, 'h155, 'h155, 'h155, err, sync);
        chk({name, "_busy"}, {31'd0, busy}, 32'd0);
        idle(4);
        chk({name, "_out"}, {2'b00, out_red, out_green, out_blue}, {2'b00, rgb('h3FF, 'h200, 'h001)});
        chk({name, "_busy2"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n    = 1'b0;
        in_word  = '0;
        in_set   = 1'b0;
        in_error = 1'b0;
        in_sync  = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(2);
        chk("reset_out", {2'b00, out_red, out_green, out_blue}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_upd", {31'd0, update}, 32'd0);

        expect_imm("imm", 2'b00, 'h3FF, 'h200, 'h001, 'h3FF, 'h200, 'h001);
        expect_drop("err_drop", 2'b00, 1'b1, 1'b1);
        expect_drop("nosync_drop", 2'b00, 1'b0, 1'b0);
        expect_drop("hold", 2'b10, 1'b0, 1'b1);
        expect_imm("blank", 2'b11, 'h155, 'h0AA, 'h033, 0, 0, 0);

`ifdef TT_HOENE_PWM_FADE_EN
        // Fade 0/0/0 -> 16/2/0 in four STEP=4 ticks.
        base = n_popped;
        sb.push_back(rgb(4, 2, 0));
        sb.push_back(rgb(8, 2, 0));
        sb.push_back(rgb(12, 2, 0));
        sb.push_back(rgb(16, 2, 0));
        send(2'b01, 16, 2, 0, 1'b0, 1'b1);
        chk("fade_busy_start", {31'd0, busy}, 32'd1);
        wait_pops("fade", base + 4, 60);
        chk("fade_busy_end", {31'd0, busy}, 32'd0);
        chk("fade_final", {2'b00, out_red, out_green, out_blue}, {2'b00, rgb(16, 2, 0)});
        idle(12);

        expect_imm("blank2", 2'b11, 0, 0, 0, 0, 0, 0);

        // Blank frame interrupts a fade toward 100.
        base = n_popped;
        sb.push_back(rgb(4, 0, 0));
        sb.push_back(rgb(8, 0, 0));
        send(2'b01, 100, 0, 0, 1'b0, 1'b1);
        wait_pops("fade_blank", base + 2, 40);
        expect_imm("blank_mid", 2'b11, 'h155, 0, 0, 0, 0, 0);
        idle(20);

        // Loss of sync freezes a fade toward 100 at red=8.
        base = n_popped;
        sb.push_back(rgb(4, 0, 0));
        sb.push_back(rgb(8, 0, 0));
        send(2'b01, 100, 0, 0, 1'b0, 1'b1);
        wait_pops("fade_sync", base + 2, 40);
        in_sync = 1'b0;
        idle(20);
        chk("sync_frozen", {2'b00, out_red, out_green, out_blue}, {2'b00, rgb(8, 0, 0)});
        chk("sync_busy", {31'd0, busy}, 32'd0);
        in_sync = 1'b1;
        idle(2);

        // Fade to the value already shown: one busy cycle, no update.
        send(2'b01, 8, 0, 0, 1'b0, 1'b1);
        chk("eq_busy", {31'd0, busy}, 32'd1);
        idle(1);
        chk("eq_busy_end", {31'd0, busy}, 32'd0);
        idle(12);
        chk("eq_out", {2'b00, out_red, out_green, out_blue}, {2'b00, rgb(8, 0, 0)});

        // Reset in the middle of a fade.
        base = n_popped;
        sb.push_back(rgb(12, 0, 0));
        send(2'b01, 100, 0, 0, 1'b0, 1'b1);
        wait_pops("fade_rst", base + 1, 20);
        rst_n = 1'b0;
        #1;
        chk("fade_rst_out", {2'b00, out_red, out_green, out_blue}, 32'd0);
        chk("fade_rst_busy", {31'd0, busy}, 32'd0);
        sb.delete();
        idle(3);
        rst_n = 1'b1;
        idle(30);
        chk("fade_rst_after", {2'b00, out_red, out_green, out_blue}, 32'd0);
`else
        expect_imm("mode01_imm", 2'b01, 100, 0, 0, 100, 0, 0);
        idle(20);
        chk("mode01_idle", {31'd0, busy}, 32'd0);
`endif

        // Reset asserted mid-run.
        expect_imm("pre_rst", 2'b00, 'h0AA, 'h155, 'h2F0, 'h0AA, 'h155, 'h2F0);
        idle(2);
        rst_n = 1'b0;
        #1;
        chk("rst_out", {2'b00, out_red, out_green, out_blue}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_upd", {31'd0, update}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(4);
        chk("post_rst_out", {2'b00, out_red, out_green, out_blue}, 32'd0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/tt_um_hoene_pwm_scheduler.md
# tt_um_hoene_pwm_scheduler

Colour-update controller between the frame decoder and the LED PWM. It takes each accepted 32-bit colour frame and decides when and how the red, green and blue PWM duty registers change: immediately, as a stepped fade toward the new target, ignored, or blanked. It sits after the protocol select/parity stage (`pwm_set`, error) and drives the `data_red/green/blue` inputs of the LED PWM.

## Interface
Parameters:
- `WIDTH`, 10, width of each colour channel.
- `TICK_DIV`, 256, clocks per fade tick. Must be ≥2.
- `STEP`, 4, maximum LSB change per channel per fade tick. Must be ≥1.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_word`  in  32  frame from serial2parallel: [31:30] mode, [29:20] red, [19:10] green, [9:0] blue.
- `in_set`  in  1  one-cycle strobe meaning a frame is complete (`pwm_set`).
- `in_error`  in  1  frame error level, sampled together with `in_set`.
- `in_sync`  in  1  protocol in-sync level.
- `out_red`, `out_green`, `out_blue`  out  WIDTH  duty values sent to the LED PWM.
- `busy`  out  1  high while an update is in progress (LOAD or FADE).
- `update`  out  1  one-cycle pulse on every cycle in which any `out_*` changes value.

## Operation
- States: IDLE, LOAD, FADE.
- Frame acceptance: a frame is accepted on a cycle with `in_set`=1, `in_error`=0 and `in_sync`=1. Otherwise the frame is dropped, with no state or output change.
- Mode 00, immediate:
  - Accepting the frame registers the target and enters LOAD.
  - LOAD copies the target to `out_*`, pulses `update`, and returns to IDLE.
- Mode 01, fade:
  - Accepting the frame registers the target and enters FADE.
  - On each tick, each channel moves toward its target by min(STEP, |target−out|).
  - The subtraction is performed WIDTH+1 bits wide, so there is no overflow and no wrap.
  - `update` pulses on each tick in which any channel moves.
  - When all three channels equal their targets, the block returns to IDLE on that same cycle.
  - A target equal to the current outputs passes through FADE for one cycle with no `update` pulse.
- Mode 10, hold: the frame is accepted but ignored. There is no state change and no `update` pulse.
- Mode 11, blank: behaves exactly like mode 00 with a target of 0/0/0.
- Accepted frame during LOAD or FADE: it replaces the target and is handled per its mode.
  - An immediate or blank frame goes to LOAD.
  - A fade frame stays in, or enters, FADE.
  - The tick counter is not reset.
- `in_sync` falling while in FADE: the fade aborts. `out_*` freeze at their current values and the state goes to IDLE.
- Tick counter:
  - Free-running 0 to TICK_DIV−1, wraps to 0.
  - A tick is the cycle where the counter equals TICK_DIV−1.
  - Its width is clog2(TICK_DIV).

## Timing
- Reset values, applied asynchronously:
  - `out_red`, `out_green`, `out_blue` = 0.
  - `busy` = 0, `update` = 0.
  - State is IDLE, tick counter is 0, targets are 0.
- Immediate and blank latency:
  - `in_set` is sampled at edge E.
  - `out_*` take the new value at edge E+1.
  - `update` is high for exactly one cycle after E+1.
- `busy` is registered. It is high in the cycle after the accepting edge and stays high until the state returns to IDLE.
- Fade: an output changes at the edge that ends a tick cycle. The first step can occur at the first tick after entering FADE; that wait is up to TICK_DIV cycles.
- `update` is always registered and is never high for two consecutive cycles unless `out_*` changed on both of those edges.
- Simultaneous `in_set` and a tick in FADE: the new target wins, and no step is taken on that edge.
- Reset mid-fade: outputs return to 0 immediately; the pending target is discarded.

## Configuration
- `TT_HOENE_PWM_FADE_EN` defined: the fade engine and mode 01 are present as described above.
- `TT_HOENE_PWM_FADE_EN` undefined:
  - Mode 01 behaves as mode 00 (immediate), and the FADE state is never entered.
  - The fade logic is removed. The tick counter and `STEP` are unused.

## Test plan
- Reset asserted mid-run, then released → all `out_*` = 0, `busy` = 0, `update` = 0.
- Immediate frame, mode 00, R=0x3FF G=0x200 B=0x001, one `in_set` pulse → after 2 edges `out_*` = 1023/512/1, a single `update` pulse, `busy` high for one cycle.
- Fade frame from 0/0/0 to 16/2/0, with TICK_DIV=8, STEP=4 and `TT_HOENE_PWM_FADE_EN` defined:
  - Red goes 4, 8, 12, 16 on four consecutive ticks.
  - Green goes 2 on the first tick.
  - Blue stays 0.
  - Four `update` pulses; `busy` falls after red reaches 16.
- `in_set` with `in_error`=1 (and separately with `in_sync`=0) carrying R=0x155 → outputs unchanged, no `update`, `busy` stays 0.
- Interruptions during a fade from 0 to 100:
  - A mode-11 frame arrives after two ticks → outputs become 0/0/0 two edges later.
  - Separately, dropping `in_sync` after two ticks → red frozen at 8 and the state returns to IDLE.
- `TT_HOENE_PWM_FADE_EN` undefined, mode-01 frame R=100 → `out_red`=100 after 2 edges with a single `update` pulse.
